// File: rtl/cacheline_arbiter_if.sv
// Line-side bus bundle around the cacheline arbiter: I-cache port, D-cache
// port and the device-side cacheline adaptor port.
// slave  : the arbiter's view (takes cache requests, drives the adaptor).
// master : the surrounding caches + adaptor.
interface cacheline_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int LINE_W = 256
);
  logic              icache_read;
  logic [ADDR_W-1:0] icache_address;
  logic [LINE_W-1:0] icache_rdata;
  logic              icache_resp;
  logic              dcache_read;
  logic              dcache_write;
  logic [ADDR_W-1:0] dcache_address;
  logic [LINE_W-1:0] dcache_wdata;
  logic [LINE_W-1:0] dcache_rdata;
  logic              dcache_resp;
  logic              adaptor_read;
  logic              adaptor_write;
  logic [ADDR_W-1:0] adaptor_address;
  logic [LINE_W-1:0] adaptor_wdata;
  logic [LINE_W-1:0] adaptor_rdata;
  logic              adaptor_resp;
  logic              arb_timeout;

  modport slave (
    input  icache_read, icache_address,
    output icache_rdata, icache_resp,
    input  dcache_read, dcache_write, dcache_address, dcache_wdata,
    output dcache_rdata, dcache_resp,
    output adaptor_read, adaptor_write, adaptor_address, adaptor_wdata,
    input  adaptor_rdata, adaptor_resp,
    output arb_timeout
  );

  modport master (
    output icache_read, icache_address,
    input  icache_rdata, icache_resp,
    output dcache_read, dcache_write, dcache_address, dcache_wdata,
    input  dcache_rdata, dcache_resp,
    input  adaptor_read, adaptor_write, adaptor_address, adaptor_wdata,
    output adaptor_rdata, adaptor_resp,
    input  arb_timeout
  );
endinterface

// File: rtl/cacheline_arbiter.sv
// Shares one cacheline adaptor between I-cache and D-cache. A request is
// latched in IDLE, forwarded while in GRANT_x, the adaptor's completion is
// routed back to the winner in the same cycle, and a one-cycle RELEASE gap
// separates transactions. Sticky watchdog flags a transfer stuck in GRANT.
module cacheline_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int LINE_W  = 256,
  parameter bit RR_EN   = 1'b1,
  parameter int TIMEOUT = 1023
) (
  input  logic                clk,
  input  logic                rst,
  cacheline_arbiter_if.slave  bus
);
  localparam int OFS   = $clog2(LINE_W / 8);
  localparam int CNT_W = $clog2(TIMEOUT + 2);
  localparam logic [ADDR_W-1:0] ALIGN_MASK = {ADDR_W{1'b1}} << OFS;
  localparam logic [CNT_W-1:0]  CNT_MAX    = CNT_W'(TIMEOUT);

  typedef enum logic [1:0] {IDLE, GRANT_I, GRANT_D, RELEASE} state_t;

  state_t            state, state_nxt;
  logic              last_d;      // 1: most recent completed grant went to D
  logic [ADDR_W-1:0] addr_q;
  logic [LINE_W-1:0] wdata_q;
  logic              wr_q;
  logic [LINE_W-1:0] irdata_q, drdata_q;
  logic [CNT_W-1:0]  wd_cnt;
  logic              timeout_q;

  logic pend_i, pend_d, pick_d, in_grant;
  logic adp_rd, adp_wr, i_resp, d_resp;

  assign pend_i   = bus.icache_read;
  assign pend_d   = bus.dcache_read | bus.dcache_write;
  // D wins when alone, when priority is fixed, or when I was served last.
  assign pick_d   = pend_d & (~pend_i | ~RR_EN | ~last_d);
  assign in_grant = (state == GRANT_I) || (state == GRANT_D);

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next state and handshake outputs; adaptor request drops in the resp cycle
  always_comb begin
    state_nxt = state;
    adp_rd    = 1'b0;
    adp_wr    = 1'b0;
    i_resp    = 1'b0;
    d_resp    = 1'b0;
    case (state)
      IDLE: begin
        if (pend_i | pend_d) state_nxt = pick_d ? GRANT_D : GRANT_I;
      end
      GRANT_I: begin
        adp_rd = ~bus.adaptor_resp;
        i_resp = bus.adaptor_resp;
        if (bus.adaptor_resp) state_nxt = RELEASE;
      end
      GRANT_D: begin
        adp_rd = ~wr_q & ~bus.adaptor_resp;
        adp_wr =  wr_q & ~bus.adaptor_resp;
        d_resp = bus.adaptor_resp;
        if (bus.adaptor_resp) state_nxt = RELEASE;
      end
      RELEASE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Request latch on the grant edge, response capture and fairness history
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q   <= '0;
      wdata_q  <= '0;
      wr_q     <= 1'b0;
      irdata_q <= '0;
      drdata_q <= '0;
      last_d   <= 1'b0;
    end else begin
      if (state == IDLE && (pend_i | pend_d)) begin
        addr_q <= (pick_d ? bus.dcache_address : bus.icache_address) & ALIGN_MASK;
        wr_q   <= pick_d & bus.dcache_write;   // write wins over a read
        if (pick_d) wdata_q <= bus.dcache_wdata;
      end
      if (i_resp) begin
        irdata_q <= bus.adaptor_rdata;
        last_d   <= 1'b0;
      end
      if (d_resp) begin
        if (!wr_q) drdata_q <= bus.adaptor_rdata;
        last_d <= 1'b1;
      end
    end
  end

  // Watchdog: counts cycles spent in GRANT; flag is sticky until rst
  always_ff @(posedge clk) begin
    if (rst) begin
      wd_cnt    <= '0;
      timeout_q <= 1'b0;
    end else begin
      if (in_grant && !bus.adaptor_resp) begin
        if (wd_cnt != CNT_MAX) wd_cnt <= wd_cnt + 1'b1;
      end else begin
        wd_cnt <= '0;
      end
      if (TIMEOUT != 0 && in_grant && (wd_cnt + 1'b1) == CNT_MAX) timeout_q <= 1'b1;
    end
  end

  assign bus.adaptor_read    = adp_rd;
  assign bus.adaptor_write   = adp_wr;
  assign bus.adaptor_address = addr_q;
  assign bus.adaptor_wdata   = wdata_q;
  assign bus.icache_resp     = i_resp;
  assign bus.dcache_resp     = d_resp;
  assign bus.icache_rdata    = i_resp ? bus.adaptor_rdata : irdata_q;
  assign bus.dcache_rdata    = (d_resp && !wr_q) ? bus.adaptor_rdata : drdata_q;
  assign bus.arb_timeout     = timeout_q;
endmodule
